// File: rtl/dice_rf_tid_sequencer.sv
// Issue-side TID sequencer for the per-port RF controller.
// Issues one read per unstalled cycle over a contiguous TID block and replays each thread as a
// writeback after the configured CGRA latency. Completion pulses `done` once all writes drain.
// Optional feature macro: DICE_TID_SEQ_PERF_EN enables the issue/stall performance counters;
// when undefined the counter ports read constant 0.
module dice_rf_tid_sequencer #(
  parameter int unsigned NUM_PORTS        = 16,
  parameter int unsigned NUM_TID          = 512,
  parameter int unsigned RF_ADDR_WIDTH    = $clog2(NUM_TID),
  parameter int unsigned MAX_CGRA_LATENCY = 64,
  parameter int unsigned LATW             = $clog2(MAX_CGRA_LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     start,
  input  logic [RF_ADDR_WIDTH-1:0] tid_base,
  input  logic [RF_ADDR_WIDTH:0]   tid_count,
  input  logic [LATW-1:0]          cgra_latency,
  input  logic [NUM_PORTS-1:0]     rd_port_mask,
  input  logic [NUM_PORTS-1:0]     wr_port_mask,
  input  logic                     stall,
  output logic [NUM_PORTS-1:0]     rd_en,
  output logic [RF_ADDR_WIDTH-1:0] rd_tid,
  output logic [NUM_PORTS-1:0]     wr_en,
  output logic [RF_ADDR_WIDTH-1:0] wr_tid,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_issue_cycles,
  output logic [31:0]              perf_stall_cycles
);

  localparam int unsigned CW = RF_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]            NumTidC = CW'(NUM_TID);
  localparam logic [RF_ADDR_WIDTH-1:0] TidMaxC = RF_ADDR_WIDTH'(NUM_TID - 1);
  localparam logic [LATW-1:0]          MaxLatC = LATW'(MAX_CGRA_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_WIDTH-1:0] tid;
  } dl_entry_t;

  // Zero latency would collide with the issue cycle, so it is treated as one.
  function automatic logic [LATW-1:0] sat_lat(input logic [LATW-1:0] l);
    if (l == '0) return LATW'(1);
    if (l > MaxLatC) return MaxLatC;
    return l;
  endfunction

  state_e                                state_q, state_d;
  logic [CW-1:0]                         k_q, k_d;
  logic [RF_ADDR_WIDTH-1:0]              tid_q, tid_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [LATW-1:0]                       lat_q, lat_d;
  logic [NUM_PORTS-1:0]                  rmask_q, rmask_d, wmask_q, wmask_d;
  logic [CW-1:0]                         outst_q, outst_d;
  dl_entry_t [MAX_CGRA_LATENCY-1:0]      dl_q, dl_d;
  logic [NUM_PORTS-1:0]                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [RF_ADDR_WIDTH-1:0]              rd_tid_q, rd_tid_d, wr_tid_q, wr_tid_d;
  logic                                  busy_q, busy_d, done_q, done_d;
  logic                                  issue, pop;

  // Next-state: FSM, issue pointer, delay line shift/insert and registered outputs.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tid_d    = tid_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    rmask_d  = rmask_q;
    wmask_d  = wmask_q;
    outst_d  = outst_q;
    rd_en_d  = '0;
    rd_tid_d = rd_tid_q;
    wr_en_d  = '0;
    wr_tid_d = wr_tid_q;
    issue    = 1'b0;
    pop      = dl_q[0].valid;

    // Entry inserted at index L-1 reaches index 0 after L-1 shifts and pops on the next edge,
    // so its write enable becomes visible exactly L cycles after its read enable.
    for (int i = 0; i < int'(MAX_CGRA_LATENCY) - 1; i++) dl_d[i] = dl_q[i+1];
    dl_d[MAX_CGRA_LATENCY-1] = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = (tid_count > NumTidC) ? NumTidC : tid_count;
          lat_d   = sat_lat(cgra_latency);
          rmask_d = rd_port_mask;
          wmask_d = wr_port_mask;
          k_d     = '0;
          tid_d   = tid_base;
          if (cnt_d == '0) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            issue   = !stall;
          end
        end
      end
      StIssue: issue = !stall;
      StDrain: if (outst_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      rd_en_d  = rmask_d;
      rd_tid_d = tid_d;
      for (int i = 0; i < int'(MAX_CGRA_LATENCY); i++) begin
        if (i == int'(lat_d) - 1) begin
          dl_d[i].valid = 1'b1;
          dl_d[i].tid   = tid_d;
        end
      end
      k_d   = k_d + 1'b1;
      tid_d = (tid_d == TidMaxC) ? '0 : tid_d + 1'b1;
      if (k_d == cnt_d) state_d = StDrain;
    end

    if (pop) begin
      wr_en_d  = wmask_q;
      wr_tid_d = dl_q[0].tid;
    end

    if (issue && !pop)      outst_d = outst_q + 1'b1;
    else if (!issue && pop) outst_d = outst_q - 1'b1;

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);

    // Flush overrides everything, including a coincident start.
    if (clr) begin
      state_d = StIdle;
      k_d     = '0;
      outst_d = '0;
      dl_d    = '0;
      rd_en_d = '0;
      wr_en_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      tid_q    <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
      outst_q  <= '0;
      dl_q     <= '0;
      rd_en_q  <= '0;
      rd_tid_q <= '0;
      wr_en_q  <= '0;
      wr_tid_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tid_q    <= tid_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
      outst_q  <= outst_d;
      dl_q     <= dl_d;
      rd_en_q  <= rd_en_d;
      rd_tid_q <= rd_tid_d;
      wr_en_q  <= wr_en_d;
      wr_tid_q <= wr_tid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rd_en  = rd_en_q;
  assign rd_tid = rd_tid_q;
  assign wr_en  = wr_en_q;
  assign wr_tid = wr_tid_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef DICE_TID_SEQ_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  // Saturating counters, cleared on an accepted start or a flush.
  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (clr || (state_q == StIdle && start)) begin
      perf_issue_d = '0;
      perf_stall_d = '0;
    end else begin
      if (|rd_en_q && perf_issue_q != '1) perf_issue_d = perf_issue_q + 1'b1;
      if (state_q == StIssue && stall && perf_stall_q != '1) perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cycles = perf_issue_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_issue_cycles = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dice_rf_tid_sequencer.sv
// Self-checking bench for dice_rf_tid_sequencer. Expected read/write/done timelines are derived
// per block from the block parameters and a per-cycle stall pattern.
module tb_dice_rf_tid_sequencer;

  localparam int MAXC = 1400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  tid_base = '0;
  logic [9:0]  tid_count = '0;
  logic [6:0]  cgra_latency = '0;
  logic [15:0] rd_port_mask = '0;
  logic [15:0] wr_port_mask = '0;
  logic        stall = 1'b0;
  logic [15:0] rd_en, wr_en;
  logic [8:0]  rd_tid, wr_tid;
  logic        busy, done;
  logic [31:0] perf_issue_cycles, perf_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  bit          stall_pat [MAXC];
  logic [15:0] erd [MAXC];
  logic [15:0] ewr [MAXC];
  logic [8:0]  erdt [MAXC];
  logic [8:0]  ewrt [MAXC];

  dice_rf_tid_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clr               (clr),
    .start             (start),
    .tid_base          (tid_base),
    .tid_count         (tid_count),
    .cgra_latency      (cgra_latency),
    .rd_port_mask      (rd_port_mask),
    .wr_port_mask      (wr_port_mask),
    .stall             (stall),
    .rd_en             (rd_en),
    .rd_tid            (rd_tid),
    .wr_en             (wr_en),
    .wr_tid            (wr_tid),
    .busy              (busy),
    .done              (done),
    .perf_issue_cycles (perf_issue_cycles),
    .perf_stall_cycles (perf_stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d run, %0d failed)", n_tests, n_fail);
    $fatal(1);
  end

  task automatic clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
  endtask

  // Runs one block starting at the next cycle (relative cycle 0) and checks every cycle
  // until two cycles past the expected done pulse, then checks the perf counters.
  task automatic run_block(input int base, input int cnt_raw, input int lat,
                           input logic [15:0] rm, input logic [15:0] wm,
                           input bit noise, input string name);
    int n, l, issued, r, last_rd, done_r, exp_issue, exp_stall, ep_i, ep_s;
    n = (cnt_raw > 512) ? 512 : cnt_raw;
    l = (lat == 0) ? 1 : ((lat > 64) ? 64 : lat);
    for (int i = 0; i < MAXC; i++) begin
      erd[i] = '0; ewr[i] = '0; erdt[i] = '0; ewrt[i] = '0;
    end
    issued = 0; r = 0; last_rd = 0; exp_issue = 0; exp_stall = 0;
    // Issue decision in cycle r (r=0 is the start cycle) shows up as a read in r+1.
    while (issued < n) begin
      if (!stall_pat[r]) begin
        erd[r+1]    = rm;
        erdt[r+1]   = 9'((base + issued) % 512);
        ewr[r+1+l]  = wm;
        ewrt[r+1+l] = 9'((base + issued) % 512);
        if (rm != 0) exp_issue++;
        issued++;
        last_rd = r + 1;
      end else if (r >= 1) begin
        exp_stall++;
      end
      r++;
    end
    done_r = (n == 0) ? 1 : last_rd + l + 1;

    @(posedge clk); #1;
    start = 1'b1; tid_base = 9'(base); tid_count = 10'(cnt_raw); cgra_latency = 7'(lat);
    rd_port_mask = rm; wr_port_mask = wm; stall = stall_pat[0];
    for (int c = 1; c <= done_r + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = stall_pat[c];
      if (noise && c <= done_r) begin
        start        = ($urandom_range(3) == 0);
        tid_base     = 9'($urandom);
        tid_count    = 10'($urandom);
        cgra_latency = 7'($urandom);
        rd_port_mask = 16'($urandom);
        wr_port_mask = 16'($urandom);
      end
      @(negedge clk);
      n_tests++;
      if (rd_en !== erd[c]) begin
        n_fail++;
        $display("FAIL %s rd_en cycle %0d: got %h expected %h", name, c, rd_en, erd[c]);
      end
      if (erd[c] != 0) begin
        n_tests++;
        if (rd_tid !== erdt[c]) begin
          n_fail++;
          $display("FAIL %s rd_tid cycle %0d: got %0d expected %0d", name, c, rd_tid, erdt[c]);
        end
      end
      n_tests++;
      if (wr_en !== ewr[c]) begin
        n_fail++;
        $display("FAIL %s wr_en cycle %0d: got %h expected %h", name, c, wr_en, ewr[c]);
      end
      if (ewr[c] != 0) begin
        n_tests++;
        if (wr_tid !== ewrt[c]) begin
          n_fail++;
          $display("FAIL %s wr_tid cycle %0d: got %0d expected %0d", name, c, wr_tid, ewrt[c]);
        end
      end
      n_tests++;
      if (done !== (c == done_r)) begin
        n_fail++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, c == done_r);
      end
      n_tests++;
      if (busy !== (c <= done_r)) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, c <= done_r);
      end
    end
    start = 1'b0; stall = 1'b0;
`ifdef DICE_TID_SEQ_PERF_EN
    ep_i = exp_issue; ep_s = exp_stall;
`else
    ep_i = 0; ep_s = 0;
`endif
    n_tests++;
    if (perf_issue_cycles !== 32'(ep_i)) begin
      n_fail++;
      $display("FAIL %s perf_issue_cycles: got %0d expected %0d", name, perf_issue_cycles, ep_i);
    end
    n_tests++;
    if (perf_stall_cycles !== 32'(ep_s)) begin
      n_fail++;
      $display("FAIL %s perf_stall_cycles: got %0d expected %0d", name, perf_stall_cycles, ep_s);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_tests++;
      if (rd_en !== 16'h0 || wr_en !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s quiet cycle %0d: got rd_en=%h wr_en=%h busy=%b done=%b expected all 0",
                 name, c, rd_en, wr_en, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rd_en !== 16'h0 || wr_en !== 16'h0 || rd_tid !== 9'h0 || wr_tid !== 9'h0 ||
        busy !== 1'b0 || done !== 1'b0 || perf_issue_cycles !== 32'h0 ||
        perf_stall_cycles !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got rd_en=%h wr_en=%h rd_tid=%0d wr_tid=%0d busy=%b done=%b pi=%0d ps=%0d expected all 0",
               rd_en, wr_en, rd_tid, wr_tid, busy, done, perf_issue_cycles, perf_stall_cycles);
    end
    rst_n = 1'b1;
    check_quiet("reset_idle", 3);
  endtask

  task automatic test_basic();
    clear_stalls();
    run_block(0, 4, 3, 16'h0003, 16'h0003, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    clear_stalls();
    run_block(510, 4, 1, 16'hffff, 16'h8001, 1'b0, "wrap");
  endtask

  task automatic test_stall();
    clear_stalls();
    stall_pat[2] = 1'b1;
    stall_pat[3] = 1'b1;
    run_block(100, 6, 2, 16'h00f0, 16'h0f00, 1'b0, "stall");
  endtask

  task automatic test_zero_count();
    clear_stalls();
    run_block(33, 0, 5, 16'hffff, 16'hffff, 1'b0, "zero_count");
  endtask

  task automatic test_perf();
    clear_stalls();
    stall_pat[1] = 1'b1;
    stall_pat[3] = 1'b1;
    run_block(7, 5, 4, 16'h0001, 16'h0002, 1'b0, "perf");
  endtask

  task automatic test_clamp();
    clear_stalls();
    run_block(7, 600, 64, 16'h1234, 16'h4321, 1'b0, "clamp");
  endtask

  task automatic test_lat_sat();
    clear_stalls();
    run_block(300, 3, 127, 16'h0100, 16'h0200, 1'b0, "lat_sat");
  endtask

  task automatic test_clr_drain();
    @(posedge clk); #1;
    start = 1'b1; tid_base = 9'd20; tid_count = 10'd3; cgra_latency = 7'd4;
    rd_port_mask = 16'hffff; wr_port_mask = 16'hffff; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (wr_en !== 16'hffff || wr_tid !== 9'd20 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_drain first write: got wr_en=%h wr_tid=%0d busy=%b expected ffff 20 1",
               wr_en, wr_tid, busy);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_quiet("clr_drain", 8);
    n_tests++;
    if (perf_issue_cycles !== 32'h0 || perf_stall_cycles !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_drain perf: got %0d/%0d expected 0/0", perf_issue_cycles,
               perf_stall_cycles);
    end
    clear_stalls();
    run_block(40, 3, 2, 16'h000f, 16'h00f0, 1'b0, "after_clr");
  endtask

  task automatic test_clr_start();
    @(posedge clk); #1;
    start = 1'b1; clr = 1'b1; tid_base = 9'd5; tid_count = 10'd5; cgra_latency = 7'd2;
    rd_port_mask = 16'hffff; wr_port_mask = 16'hffff;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    check_quiet("clr_start", 10);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; tid_base = 9'd60; tid_count = 10'd10; cgra_latency = 7'd5;
    rd_port_mask = 16'h00ff; wr_port_mask = 16'hff00; stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (wr_en !== 16'h0 || rd_en !== 16'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid immediate: got wr_en=%h rd_en=%h busy=%b expected 0 0 0",
               wr_en, rd_en, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("reset_mid", 10);
    clear_stalls();
    run_block(2, 2, 3, 16'h0f0f, 16'hf0f0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int lat;
      clear_stalls();
      for (int i = 0; i < 200; i++) stall_pat[i] = ($urandom_range(99) < 25);
      lat = ($urandom_range(1) == 0) ? $urandom_range(8) : $urandom_range(127);
      run_block($urandom_range(511), $urandom_range(40), lat, 16'($urandom),
                16'($urandom), 1'b1, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_count();
    test_perf();
    test_lat_sat();
    test_clr_drain();
    test_clr_start();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dice_rf_tid_sequencer.md
# dice_rf_tid_sequencer

Issue-side sequencer for the per-port predicate/general register file controller. Given a contiguous block of thread IDs, it issues one read per cycle (`rd_en`/`rd_tid`) toward the RF controller, tracks each issued thread through the configured CGRA pipeline latency, and issues the matching writeback (`wr_en`/`wr_tid`) when that thread's result returns. It sits between the CTA dispatcher and the RF control block and reports completion once all in-flight threads have written back.

## Interface
- `NUM_PORTS`, 16, number of RF ports/banks driven by the enable vectors
- `NUM_TID`, 512, threads per RF; TIDs wrap modulo this value
- `RF_ADDR_WIDTH`, `$clog2(NUM_TID)`, TID width
- `MAX_CGRA_LATENCY`, 64, maximum read-to-writeback delay in cycles; sizes the delay line
- `LATW`, `$clog2(MAX_CGRA_LATENCY+1)`, width of the latency config

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous flush: state to IDLE, delay line emptied, no `done`
- `start`  in  1  begin a block; accepted only in IDLE
- `tid_base`  in  RF_ADDR_WIDTH  first TID, sampled on accepted `start`
- `tid_count`  in  RF_ADDR_WIDTH+1  number of TIDs, sampled on `start`
- `cgra_latency`  in  LATW  read-to-writeback delay, sampled on `start`
- `rd_port_mask`  in  NUM_PORTS  ports read per thread, sampled on `start`
- `wr_port_mask`  in  NUM_PORTS  ports written per thread, sampled on `start`
- `stall`  in  1  blocks new reads; in-flight writebacks continue
- `rd_en`  out  NUM_PORTS  per-port read enable
- `rd_tid`  out  RF_ADDR_WIDTH  read TID
- `wr_en`  out  NUM_PORTS  per-port write enable
- `wr_tid`  out  RF_ADDR_WIDTH  write TID
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `perf_issue_cycles`, `perf_stall_cycles`  out  32 each  performance counters (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch config, set issue index k=0, outstanding=0. If `tid_count`==0, go to DONE; otherwise go to ISSUE.
- ISSUE: each cycle with `stall`=0, drive `rd_en`=`rd_port_mask` and `rd_tid`=(`tid_base`+k) mod NUM_TID, push {valid, tid} into the delay line, k++, outstanding++. After the issue with k=`tid_count`-1, go to DRAIN. With `stall`=1: `rd_en`=0, no push, state held.
- Delay line: an entry pushed at cycle t emerges at t+L, where L=max(`cgra_latency`,1). Values above MAX_CGRA_LATENCY saturate to MAX_CGRA_LATENCY. On an emerging valid entry, drive `wr_en`=`wr_port_mask` and `wr_tid`=entry TID, and decrement outstanding. A push and a pop in the same cycle leave outstanding unchanged.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` outside IDLE is ignored. Config inputs are don't-care outside the `start` cycle.
- TID wrap: `tid_base`=510, count 4, NUM_TID=512 gives TIDs 510, 511, 0, 1.
- `tid_count` above NUM_TID is clamped to NUM_TID.

## Timing
- Reset: state IDLE; `rd_en`, `wr_en`, `rd_tid`, `wr_tid`, `busy`, `done` and the perf counters all 0; delay line invalid.
- All outputs are registered.
- The first `rd_en` appears 1 cycle after the accepted `start` cycle.
- A thread's `wr_en` appears exactly L cycles after its `rd_en`.
- With no stalls, `done` appears at start+`tid_count`+L+1.
- `clr` takes priority over all state updates. If `clr` and `start` arrive in the same cycle, the block ends in IDLE and `start` is dropped.
- Asserting `rst_n` low mid-block discards all in-flight writebacks immediately.

## Configuration
- `DICE_TID_SEQ_PERF_EN` defined:
  - `perf_issue_cycles` counts cycles with a non-zero `rd_en`.
  - `perf_stall_cycles` counts ISSUE cycles with `stall`=1.
  - Both counters clear on an accepted `start` and on `clr`, and saturate at 2^32-1.
- Not defined: both ports remain present and are tied to 0. No counter logic is instantiated.

## Test plan
- base=0, count=4, latency=3, masks=16'h0003, no stall: `rd_tid` 0..3 on cycles 1..4; `wr_tid` 0..3 on cycles 4..7 with `wr_en`=16'h0003; `done` at cycle 8.
- base=510, count=4, latency=1: `rd_tid` sequence 510, 511, 0, 1; writes follow 1 cycle later in the same order.
- count=6, latency=2, `stall` high during cycles 2–3: reads resume with no TID skipped or duplicated; all 6 writes occur exactly 2 cycles after their reads; `done` is delayed by 2 cycles.
- count=0: `done` at cycle 1; no `rd_en` or `wr_en` ever asserted.
- `clr` mid-DRAIN with 2 writes outstanding: `wr_en` is 0 from the next cycle; no `done`; `busy`=0; a new `start` is accepted normally.
- With `DICE_TID_SEQ_PERF_EN`: count=5, 2 stall cycles gives `perf_issue_cycles`=5 and `perf_stall_cycles`=2. Without the macro, both read 0.
